// File: rtl/cpu_defs.sv
// Shared CPU definitions: divider FSM states, default datapath width and
// the quotient returned for a divide by zero.
package cpu_defs;

   localparam int unsigned DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_BUSY,
      DIV_DONE
   } div_state_t;

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift {rem,quo} left,
// subtract the divisor and keep the difference when it is non-negative.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      trial   = shifted - {1'b0, divisor};
      // rem < divisor is invariant, so a non-negative trial always fits WIDTH bits
      if (!trial[WIDTH]) begin
         rem_next = trial[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = shifted[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EXE stage (DIV/DIVU).
// Raises stall_div from accept until the last iteration; result in DONE.
module div_unit
   import cpu_defs::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             signed_div,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             flush,
   output logic             stall_div,
   output logic             result_valid,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvsr_q;
   logic             sign_q;
   logic             sign_r;
   logic             dzero_q;
   logic             rv_q;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   always_comb begin
      a_neg = signed_div & dividend[WIDTH-1];
      b_neg = signed_div & divisor[WIDTH-1];
      a_mag = a_neg ? -dividend : dividend;
      b_mag = b_neg ? -divisor : divisor;
   end

   // Gated by resetn so no stall is requested while the block is held in reset
   assign stall_div = resetn &
                      (((state == DIV_IDLE) & start & ~flush) | (state == DIV_BUSY));

   assign result_valid = rv_q & ~flush;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvsr_q),
      .rem_next (rem_nx),
      .quo_next (quo_nx)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= DIV_IDLE;
         cnt       <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         dzero_q   <= 1'b0;
         rv_q      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         rv_q <= 1'b0;
         case (state)
            DIV_IDLE: begin
               if (start && !flush) begin
                  rem_q   <= '0;
                  quo_q   <= a_mag;
                  dvsr_q  <= b_mag;
                  sign_q  <= a_neg ^ b_neg;
                  sign_r  <= a_neg;
                  dzero_q <= (divisor == '0);
                  cnt     <= '0;
                  state   <= DIV_BUSY;
               end
            end
            DIV_BUSY: begin
               if (flush) begin
                  state <= DIV_IDLE;
               end else begin
                  rem_q <= rem_nx;
                  quo_q <= quo_nx;
                  cnt   <= cnt + CNT_W'(1);
                  // Final iteration: results are registered straight from the step outputs
                  if (cnt == CNT_W'(WIDTH - 1)) begin
                     state     <= DIV_DONE;
                     rv_q      <= 1'b1;
                     quotient  <= dzero_q ? WIDTH'(DIV_ZERO_Q) :
                                  (sign_q ? -quo_nx : quo_nx);
                     remainder <= sign_r ? -rem_nx : rem_nx;
                  end
               end
            end
            DIV_DONE: begin
               state <= DIV_IDLE;
            end
            default: begin
               state <= DIV_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, flush/reset/back-to-back
// sequences and randomized operations checked against an arithmetic model.
module tb_div_unit;

   logic        clk;
   logic        resetn;
   logic        start;
   logic        signed_div;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        flush;
   logic        stall_div;
   logic        result_valid;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int errors = 0;
   int checks = 0;

   div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .signed_div   (signed_div),
      .dividend     (dividend),
      .divisor      (divisor),
      .flush        (flush),
      .stall_div    (stall_div),
      .result_valid (result_valid),
      .quotient     (quotient),
      .remainder    (remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          sd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eq;
      logic [31:0] er;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      longint sa;
      longint sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!sd) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end
   endfunction

   // Accepts in the first cycle, then scrambles operand inputs while busy; returns
   // sitting in the first non-stalled cycle with start still high.
   task automatic do_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                         input bit flush_done, output logic [31:0] q, output logic [31:0] r,
                         output int stalls, output bit valid);
      @(negedge clk);
      start = 1'b1; signed_div = sd; dividend = a; divisor = b; flush = 1'b0;
      #1;
      stalls = 0; valid = 1'b0; q = 'x; r = 'x;
      for (int i = 0; i < 100; i++) begin
         if (stall_div) begin
            stalls++;
         end else begin
            if (flush_done) begin
               flush = 1'b1;
               #1;
            end
            valid = result_valid;
            q = quotient;
            r = remainder;
            break;
         end
         @(negedge clk);
         dividend = $urandom; divisor = $urandom;
         #1;
      end
   endtask

   task automatic run_check(input string name, input bit sd, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                            input bit flush_done);
      logic [31:0] q, r;
      int          stalls;
      bit          valid;
      do_div(sd, a, b, flush_done, q, r, stalls, valid);
      check({name, "_stalls"}, 32'(stalls), 32'd33);
      check({name, "_valid"}, 32'(valid), 32'(!flush_done));
      if (!flush_done) begin
         check({name, "_q"}, q, eq);
         check({name, "_r"}, r, er);
      end
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check({name, "_pulse_end"}, 32'(result_valid), 32'd0);
      check({name, "_idle_stall"}, 32'(stall_div), 32'd0);
   endtask

   vec_t        vecs[$];
   logic [31:0] q, r, eq, er;
   int          stalls;
   bit          valid;
   bit          seen;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs.push_back('{0, 32'd100,        32'd7,          32'd14,         32'd2});
      vecs.push_back('{1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF});
      vecs.push_back('{1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1});
      vecs.push_back('{0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234});
      vecs.push_back('{1, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234});
      vecs.push_back('{1, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF9C});
      vecs.push_back('{1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0});
      vecs.push_back('{0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0});
      vecs.push_back('{0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1});
      vecs.push_back('{1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF});

      // Reset with start pending: no stall request, cleared outputs
      resetn = 1'b0; start = 1'b1; signed_div = 1'b0; dividend = 32'd5; divisor = 32'd1;
      flush = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_stall", 32'(stall_div), 32'd0);
      check("reset_valid", 32'(result_valid), 32'd0);
      check("reset_q", quotient, 32'd0);
      check("reset_r", remainder, 32'd0);
      @(negedge clk);
      resetn = 1'b1; start = 1'b0;

      foreach (vecs[i])
         run_check($sformatf("vec%0d", i), vecs[i].sd, vecs[i].a, vecs[i].b,
                   vecs[i].eq, vecs[i].er, 1'b0);

      // flush in IDLE together with start: not accepted
      @(negedge clk);
      start = 1'b1; flush = 1'b1; dividend = 32'd40; divisor = 32'd3;
      #1;
      check("idle_flush_stall", 32'(stall_div), 32'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check("idle_flush_not_accepted", 32'(stall_div), 32'd0);

      // Back-to-back: start stays high across DONE with new operands
      do_div(1'b0, 32'd1000, 32'd7, 1'b0, q, r, stalls, valid);
      check("b2b1_stalls", 32'(stalls), 32'd33);
      check("b2b1_valid", 32'(valid), 32'd1);
      check("b2b1_q", q, 32'd142);
      check("b2b1_r", r, 32'd6);
      run_check("b2b2", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

      // flush during DONE suppresses the valid pulse
      run_check("done_flush", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b1);

      // Reset in BUSY cycle 20: immediate clear, nothing after release
      run_check("pre_rst", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
      @(negedge clk);
      start = 1'b1; signed_div = 1'b0; dividend = 32'd500; divisor = 32'd7;
      repeat (20) @(negedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check("midrst_stall", 32'(stall_div), 32'd0);
      check("midrst_valid", 32'(result_valid), 32'd0);
      check("midrst_q", quotient, 32'd0);
      check("midrst_r", remainder, 32'd0);
      @(negedge clk);
      resetn = 1'b1; start = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (result_valid || stall_div) seen = 1'b1;
      end
      check("midrst_no_result", 32'(seen), 32'd0);

      // Flush in BUSY cycle 10: outputs hold the previous result
      run_check("pre_flush", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
      @(negedge clk);
      start = 1'b1; signed_div = 1'b0; dividend = 32'd50; divisor = 32'd5; flush = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      check("busy_flush_stall", 32'(stall_div), 32'd1);
      check("busy_flush_valid", 32'(result_valid), 32'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check("post_flush_stall", 32'(stall_div), 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (result_valid) seen = 1'b1;
      end
      check("post_flush_no_valid", 32'(seen), 32'd0);
      check("post_flush_q_hold", quotient, 32'd333);
      check("post_flush_r_hold", remainder, 32'd1);
      run_check("after_flush", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

      // Randomized operations against the arithmetic model
      for (int n = 0; n < 40; n++) begin
         bit          sd;
         logic [31:0] a, b;
         sd = 1'($urandom);
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 20));
            2:       b = -32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         ref_div(sd, a, b, eq, er);
         run_check($sformatf("rnd%0d", n), sd, a, b, eq, er, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the EXE stage of the 5-stage MIPS pipeline.
- Runs DIV/DIVU and produces the `stall_div` request that the hazard unit receives as `stall_divE`.
- The hazard unit uses that signal to freeze F/D/E until quotient and remainder are ready for HI/LO.
- This block is the request side of the stall handshake; the hazard unit is the consumer.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  a DIV/DIVU is in E; held high for as long as the instruction stays in E.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  input  WIDTH  rs value after E-stage forwarding.
- divisor  input  WIDTH  rt value after E-stage forwarding.
- flush  input  1  E-stage annul (flushE or exception); aborts the operation.
- stall_div  output  1  combinational stall request to the hazard unit.
- result_valid  output  1  one-cycle pulse; quotient/remainder are valid.
- quotient  output  WIDTH  LO value.
- remainder  output  WIDTH  HI value.

Behaviour:
- Reset (async, resetn=0): state=IDLE, counter=0, result_valid=0, quotient=0, remainder=0, internal registers cleared. stall_div=0 while reset is asserted.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If start=1 and flush=0: latch |dividend|, |divisor|, sign_q=(a31^b31)&signed_div, sign_r=a31&signed_div. Clear the partial remainder and counter. Go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, one iteration per cycle:
  - {rem,quo} shifted left 1; trial = rem - divisor.
  - If trial is non-negative, rem=trial and quo bit0=1.
  - Counter increments. After WIDTH iterations (counter==WIDTH-1 at the clock edge), go to DONE.
- DONE (exactly one cycle):
  - result_valid=1.
  - quotient = sign_q ? -quo : quo; remainder = sign_r ? -rem : rem. Both are registered outputs, held until the next accept.
  - Next state is IDLE.
- stall_div = (state==IDLE & start & ~flush) | (state==BUSY). It is combinational because the hazard unit needs it in the accepting cycle.
- Timing for accept in cycle 0:
  - stall_div is high in cycles 0..WIDTH (33 cycles for WIDTH=32).
  - Cycle WIDTH+1 is DONE: stall_div=0, result_valid=1, and the E stage advances at that clock edge.
- Re-accept: DONE never accepts. The instruction that follows enters E at the end of DONE, and IDLE accepts it in the next cycle. Back-to-back divides cost exactly 1 idle cycle between operations.
- flush in BUSY or DONE: next state is IDLE, result_valid is forced to 0 that cycle, and quotient/remainder keep their old values. stall_div follows the equation above (in BUSY it stays high in the flush cycle).
- flush in IDLE with start=1: not accepted; stall_div=0.
- Divide by zero (divisor==0, either mode): no trap, full latency. quotient = all ones (0xFFFFFFFF); remainder = dividend as supplied.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0. This falls out of the magnitude arithmetic and needs no special case.
- Operands are sampled only at accept. Later changes on the dividend/divisor inputs, e.g. from forwarding, are ignored.
- resetn deasserted mid-operation: the block returns to IDLE immediately and asynchronously. No result_valid is produced.

Decomposition:
- Shared package (cpu_defs) holds:
  - div FSM state encodings DIV_IDLE/DIV_BUSY/DIV_DONE;
  - WIDTH default;
  - the divide-by-zero quotient constant.
- One natural sub-module: div_step, a combinational single restoring iteration. Inputs {rem, quo, divisor}; outputs next {rem, quo}.
- Sign handling and the FSM stay in div_unit.

Test Plan:
- Unsigned 100/7 (signed_div=0), start held → stall_div high exactly 33 cycles, then result_valid pulse with quotient=14, remainder=2.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also 7/-2 → quotient=0xFFFFFFFD, remainder=1.
- Divide by zero 0x1234/0 (both modes) → quotient=0xFFFFFFFF, remainder=0x1234, latency unchanged. Signed 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0.
- flush asserted in cycle 10 of BUSY → state IDLE next cycle, stall_div drops, no result_valid, outputs keep prior values. A subsequent start is accepted normally.
- Back-to-back divides: start held across the DONE cycle with new operands 9/4 → one idle-accept cycle, then a second 33-cycle stall and quotient=2, remainder=1.
- resetn pulsed low in cycle 20 of BUSY → all outputs 0 immediately, stall_div=0, no result_valid after release.
